// File: rtl/e203_reset_src_ctrl_pkg.sv
// Shared encodings for the reset-source aggregator.
package e203_reset_src_ctrl_pkg;

    localparam int CAUSE_W = 5;

    // Bit positions inside the sticky cause register
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_BTN = 1;
    localparam int CAUSE_WDG = 2;
    localparam int CAUSE_SW  = 3;
    localparam int CAUSE_DBG = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } rst_state_t;

endpackage

// File: rtl/e203_rst_btn_debounce.sv
// Pushbutton synchroniser plus stable-level debouncer.
// btn_level is the accepted level of the active-low button (1 = released).
module e203_rst_btn_debounce #(
    parameter int SYNC_LEVELS  = 2,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_rst_n_raw,
    output logic btn_level
);

    localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SYNC_LEVELS-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sample;

    assign sample = sync_q[SYNC_LEVELS-1];

    // Synchroniser chain; resets to "released" so a held button after reset
    // is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= btn_rst_n_raw;
            for (int i = 1; i < SYNC_LEVELS; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Count consecutive samples that disagree with the accepted level; flip
    // once DEBOUNCE_CNT of them have been seen in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            btn_level <= 1'b1;
        end else if (sample != btn_level) begin
            if (cnt_q == CNT_MAX) begin
                btn_level <= sample;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/e203_reset_src_ctrl.sv
// Reset-source aggregator: merges POR, button, watchdog, software and debug
// reset requests into one stretched, registered active-low reset and keeps
// a sticky last-cause register for firmware.
module e203_reset_src_ctrl
    import e203_reset_src_ctrl_pkg::*;
#(
    parameter int SYNC_LEVELS  = 2,
    parameter int DEBOUNCE_CNT = 50000,
    parameter int PULSE_CYC    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               test_mode,
    input  logic               btn_rst_n_raw,
    input  logic               wdg_rst_req,
    input  logic               sw_rst_req,
    input  logic               dbg_ndm_rst_req,
    input  logic               cause_clr,
    output logic               rst_out_n,
    output logic               rst_active,
    output logic [CAUSE_W-1:0] rst_cause
);

    localparam int PCNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [PCNT_W-1:0] RELOAD = PCNT_W'(PULSE_CYC - 1);

    rst_state_t         state_q, state_d;
    logic [PCNT_W-1:0]  cnt_q, cnt_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [CAUSE_W-1:0] cur_src;
    logic               rst_out_q, rst_out_d;
    logic               btn_level, btn_press, btn_press_q, btn_rise;
    logic               pulse_req, level_req;

    e203_rst_btn_debounce #(
        .SYNC_LEVELS  (SYNC_LEVELS),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_btn (
        .clk           (clk),
        .rst           (rst),
        .btn_rst_n_raw (btn_rst_n_raw),
        .btn_level     (btn_level)
    );

    assign btn_press = ~btn_level;
    assign btn_rise  = btn_press & ~btn_press_q;
    assign pulse_req = wdg_rst_req | sw_rst_req | btn_rise;
    assign level_req = btn_press | dbg_ndm_rst_req;

    // Sources asserting this cycle, laid out as the cause register
    always_comb begin
        cur_src            = '0;
        cur_src[CAUSE_BTN] = btn_press;
        cur_src[CAUSE_WDG] = wdg_rst_req;
        cur_src[CAUSE_SW]  = sw_rst_req;
        cur_src[CAUSE_DBG] = dbg_ndm_rst_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_ASSERT;
        else     state_q <= state_d;
    end

    // Next-state: pulses (re)enter ASSERT, levels park in HOLD
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pulse_req || level_req) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (pulse_req)         state_d = ST_ASSERT;
                else if (cnt_q == '0)  state_d = level_req ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (pulse_req)         state_d = ST_ASSERT;
                else if (!level_req)   state_d = ST_IDLE;
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    // Output decode from the next state so the reset drive is a plain flop
    always_comb begin
        rst_out_d = (state_d == ST_IDLE);
    end

    // Width counter and cause register next values
    always_comb begin
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (pulse_req || level_req) begin
                    cnt_d   = RELOAD;
                    cause_d = cur_src;      // last-cause: replace, request beats clear
                end else if (cause_clr) begin
                    cause_d = '0;
                end
            end
            ST_ASSERT: begin
                cause_d = cause_q | cur_src;
                if (pulse_req)         cnt_d = RELOAD;
                else if (cnt_q != '0)  cnt_d = cnt_q - PCNT_W'(1);
            end
            ST_HOLD: begin
                cause_d = cause_q | cur_src;
                if (pulse_req) cnt_d = RELOAD;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= RELOAD;
            cause_q     <= CAUSE_W'(1) << CAUSE_POR;
            rst_out_q   <= 1'b0;
            btn_press_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            rst_out_q   <= rst_out_d;
            btn_press_q <= btn_press;
        end
    end

    // Scan bypass makes reset directly controllable from the rst pin
    assign rst_out_n  = test_mode ? ~rst : rst_out_q;
    assign rst_active = ~rst_out_q;
    assign rst_cause  = cause_q;

endmodule
